// File: rtl/dma_pkg.sv
// Shared definitions for the single-channel Wishbone DMA engine: FSM encoding,
// direction constants and the default bus timeout.
package dma_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_HOLD = 3'd2;
    localparam logic [2:0] S_WR_WAIT = 3'd3;
    localparam logic [2:0] S_WR_REQ  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic DIR_M2S = 1'b0;
    localparam logic DIR_S2M = 1'b1;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    function automatic logic is_bus_state(input logic [2:0] state);
        return (state == S_RD_REQ) || (state == S_WR_REQ);
    endfunction

endpackage

// File: rtl/dma_wb_req.sv
// Single-beat classic Wishbone request driver with ack timeout; the request is
// held for as long as the FSM keeps i_req high.
import dma_pkg::*;

module dma_wb_req #(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_dat,
    input  logic        i_ack,
    output logic        o_cyc,
    output logic        o_stb,
    output logic        o_we,
    output logic [3:0]  o_sel,
    output logic [31:0] o_adr,
    output logic [31:0] o_dat,
    output logic        o_done,
    output logic        o_timeout
);

    logic [7:0] r_cnt;

    // Counter is zero whenever no request is open, so every request starts fresh.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 8'd0;
        end else if (!i_req || i_ack) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    always_comb begin
        o_cyc     = i_req;
        o_stb     = i_req;
        o_we      = i_req & i_we;
        o_sel     = i_req ? 4'hF : 4'h0;
        o_adr     = i_req ? i_adr : 32'd0;
        o_dat     = (i_req && i_we) ? i_dat : 32'd0;
        o_done    = i_req & i_ack;
        o_timeout = i_req & ~i_ack & (r_cnt == 8'(TIMEOUT - 1));
    end

endmodule

// File: rtl/wb_dma_engine.sv
// Single-channel DMA master: moves a block of 32-bit words between RAM (Wishbone)
// and an AXI-Stream, one bus access at a time.
import dma_pkg::*;

module wb_dma_engine #(
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic             start_i,
    input  logic             dir_i,
    input  logic [31:0]      base_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             wbm_stb_o,
    output logic             wbm_cyc_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [31:0]      wbm_dat_i,
    output logic             m_tvalid_o,
    output logic [31:0]      m_tdata_o,
    output logic             m_tlast_o,
    input  logic             m_tready_i,
    input  logic             s_tvalid_i,
    input  logic [31:0]      s_tdata_i,
    output logic             s_tready_o
);

    logic [2:0]       r_state;
    logic [31:0]      r_addr;
    logic [LEN_W-1:0] r_remain;
    logic [31:0]      r_buf;
    logic             r_err;

    logic [2:0] w_state_d;
    logic       w_req;
    logic       w_we;
    logic       w_bus_done;
    logic       w_timeout;
    logic       w_accept;
    logic       w_adv;
    logic       w_cap_rd;
    logic       w_cap_wr;
    logic       w_set_err;
    logic       w_last;

    assign w_req  = is_bus_state(r_state);
    assign w_we   = (r_state == S_WR_REQ);
    assign w_last = (r_remain == LEN_W'(1));

    dma_wb_req #(
        .TIMEOUT (TIMEOUT)
    ) u_wb_req (
        .i_clk     (wb_clk_i),
        .i_rst_n   (wb_rst_n_i),
        .i_req     (w_req),
        .i_we      (w_we),
        .i_adr     (r_addr),
        .i_dat     (r_buf),
        .i_ack     (wbm_ack_i),
        .o_cyc     (wbm_cyc_o),
        .o_stb     (wbm_stb_o),
        .o_we      (wbm_we_o),
        .o_sel     (wbm_sel_o),
        .o_adr     (wbm_adr_o),
        .o_dat     (wbm_dat_o),
        .o_done    (w_bus_done),
        .o_timeout (w_timeout)
    );

    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        w_adv     = 1'b0;
        w_cap_rd  = 1'b0;
        w_cap_wr  = 1'b0;
        w_set_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_accept = 1'b1;
                    if (len_i == '0) begin
                        w_state_d = S_DONE;
                    end else if (dir_i == DIR_S2M) begin
                        w_state_d = S_WR_WAIT;
                    end else begin
                        w_state_d = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                if (w_bus_done) begin
                    w_cap_rd  = 1'b1;
                    w_state_d = S_RD_HOLD;
                end else if (w_timeout) begin
                    w_set_err = 1'b1;
                    w_state_d = S_DONE;
                end
            end
            S_RD_HOLD: begin
                if (m_tready_i) begin
                    w_adv     = 1'b1;
                    w_state_d = w_last ? S_DONE : S_RD_REQ;
                end
            end
            S_WR_WAIT: begin
                if (s_tvalid_i) begin
                    w_cap_wr  = 1'b1;
                    w_state_d = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (w_bus_done) begin
                    w_adv     = 1'b1;
                    w_state_d = w_last ? S_DONE : S_WR_WAIT;
                end else if (w_timeout) begin
                    w_set_err = 1'b1;
                    w_state_d = S_DONE;
                end
            end
            S_DONE:  w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state  <= S_IDLE;
            r_addr   <= 32'd0;
            r_remain <= '0;
            r_buf    <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_addr   <= {base_i[31:2], 2'b00};
                r_remain <= len_i;
                r_err    <= 1'b0;
            end
            // Address wraps naturally modulo 2^32.
            if (w_adv) begin
                r_remain <= r_remain - LEN_W'(1);
                r_addr   <= r_addr + 32'd4;
            end
            if (w_cap_rd) begin
                r_buf <= wbm_dat_i;
            end
            if (w_cap_wr) begin
                r_buf <= s_tdata_i;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        busy_o     = (r_state != S_IDLE) && (r_state != S_DONE);
        done_o     = (r_state == S_DONE);
        err_o      = r_err;
        m_tvalid_o = (r_state == S_RD_HOLD);
        m_tdata_o  = (r_state == S_RD_HOLD) ? r_buf : 32'd0;
        m_tlast_o  = (r_state == S_RD_HOLD) && w_last;
        s_tready_o = (r_state == S_WR_WAIT);
    end

endmodule

// File: tb/tb_wb_dma_engine.sv
// Directed bench for wb_dma_engine with a 1-cycle-ack RAM model, stream source/sink
// and a negedge monitor.
`timescale 1ns/1ps

module tb_wb_dma_engine;

    localparam int LEN_W = 16;
    localparam int TO    = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             dir = 1'b0;
    logic [31:0]      base = 32'd0;
    logic [LEN_W-1:0] len = '0;
    logic             busy, done, err;
    logic             stb, cyc, we;
    logic [3:0]       sel;
    logic [31:0]      adr, dat_o, dat_i;
    logic             ack;
    logic             m_tvalid, m_tlast;
    logic [31:0]      m_tdata;
    logic             m_tready = 1'b1;
    logic             s_tvalid = 1'b0;
    logic [31:0]      s_tdata = 32'd0;
    logic             s_tready;

    always #5 clk = ~clk;

    wb_dma_engine #(.LEN_W(LEN_W), .TIMEOUT(TO)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .start_i    (start),
        .dir_i      (dir),
        .base_i     (base),
        .len_i      (len),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .wbm_stb_o  (stb),
        .wbm_cyc_o  (cyc),
        .wbm_we_o   (we),
        .wbm_sel_o  (sel),
        .wbm_adr_o  (adr),
        .wbm_dat_o  (dat_o),
        .wbm_ack_i  (ack),
        .wbm_dat_i  (dat_i),
        .m_tvalid_o (m_tvalid),
        .m_tdata_o  (m_tdata),
        .m_tlast_o  (m_tlast),
        .m_tready_i (m_tready),
        .s_tvalid_i (s_tvalid),
        .s_tdata_i  (s_tdata),
        .s_tready_o (s_tready)
    );

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RAM model: ack one cycle after request, no ack while noack is set.
    logic [31:0] mem [0:63];
    logic        noack = 1'b0;
    logic        ack_q;
    logic [31:0] acc_adr[$];
    logic        acc_we[$];
    int          bad_sel = 0;

    assign ack   = ack_q;
    assign dat_i = mem[adr[7:2]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= cyc && stb && !ack_q && !noack;
            if (cyc && stb && ack_q) begin
                acc_adr.push_back(adr);
                acc_we.push_back(we);
                if (sel != 4'hF) bad_sel++;
                if (we) mem[adr[7:2]] <= dat_o;
            end
        end
    end

    // Output-stream sink and protocol monitor.
    logic [31:0] out_q[$];
    logic        out_last[$];
    int          done_cnt = 0, cyc_cnt = 0, stall_bad = 0, hold_bus_bad = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic        prev_last = 1'b0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (cyc) cyc_cnt++;
        if (m_tvalid && cyc) hold_bus_bad++;
        if (prev_stall && (!m_tvalid || m_tdata != prev_data || m_tlast != prev_last))
            stall_bad++;
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
        if (m_tvalid && m_tready) begin
            out_q.push_back(m_tdata);
            out_last.push_back(m_tlast);
        end
    end

    int rdy_mode = 0;
    int rdy_ctr = 0;
    always @(posedge clk) begin
        #1;
        rdy_ctr++;
        m_tready = (rdy_mode == 0) || (rdy_ctr % 4 == 0);
    end

    // Input-stream source.
    logic [31:0] src_data [0:7];
    int          src_len = 0, src_idx = 0;
    logic        src_hs = 1'b0;
    always @(negedge clk) src_hs = s_tvalid && s_tready;
    always @(posedge clk) begin
        #1;
        if (src_hs) src_idx++;
        s_tvalid = (src_idx < src_len);
        s_tdata  = src_data[src_idx[2:0]];
    end

    task automatic clr();
        out_q.delete();
        out_last.delete();
        acc_adr.delete();
        acc_we.delete();
        done_cnt = 0;
        cyc_cnt = 0;
        stall_bad = 0;
        hold_bus_bad = 0;
        bad_sel = 0;
    endtask

    task automatic do_start(input logic d, input logic [31:0] b, input logic [LEN_W-1:0] l);
        @(posedge clk); #1;
        clr();
        start = 1'b1; dir = d; base = b; len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, input string tag);
        bit seen = 0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic set_src(input int n);
        @(negedge clk);
        src_idx = 0;
        src_len = n;
    endtask

    initial begin
        int k;
        bit seen;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        for (int i = 0; i < 8; i++) src_data[i] = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {26'd0, busy, done, err, cyc, m_tvalid, s_tready}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ctrl", {27'd0, busy, done, err, cyc, stb}, 32'd0);

        // mem->stream, len 4
        for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
        do_start(1'b0, 32'h3800_0000, 16'd4);
        @(negedge clk);
        chk("m2s_busy_cyc", {30'd0, busy, cyc}, 32'd3);
        chk("m2s_first_adr", adr, 32'h3800_0000);
        wait_done(40, "m2s");
        repeat (3) @(negedge clk);
        chk("m2s_n_words", 32'(out_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("m2s_word%0d", i), out_q[i], 32'(i + 1));
            chk($sformatf("m2s_last%0d", i), 32'(out_last[i]), (i == 3) ? 32'd1 : 32'd0);
            chk($sformatf("m2s_adr%0d", i), acc_adr[i], 32'h3800_0000 + 32'(4 * i));
        end
        chk("m2s_done_cnt", 32'(done_cnt), 32'd1);
        chk("m2s_err", 32'(err), 32'd0);

        // stream->mem, len 3
        src_data[0] = 32'hA; src_data[1] = 32'hB; src_data[2] = 32'hC;
        set_src(3);
        do_start(1'b1, 32'h3800_0042, 16'd3);
        wait_done(40, "s2m");
        repeat (3) @(negedge clk);
        chk("s2m_n_acc", 32'(acc_adr.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("s2m_adr%0d", i), acc_adr[i], 32'h3800_0040 + 32'(4 * i));
            chk($sformatf("s2m_we%0d", i), 32'(acc_we[i]), 32'd1);
        end
        chk("s2m_sel", 32'(bad_sel), 32'd0);
        chk("s2m_mem0", mem[16], 32'hA);
        chk("s2m_mem1", mem[17], 32'hB);
        chk("s2m_mem2", mem[18], 32'hC);
        chk("s2m_no_out", 32'(out_q.size()), 32'd0);

        // Backpressure: tready 1 on / 3 off
        for (int i = 0; i < 8; i++) mem[32 + i] = 32'h100 + 32'(i);
        rdy_mode = 1;
        do_start(1'b0, 32'h3800_0080, 16'd8);
        wait_done(200, "bp");
        repeat (2) @(negedge clk);
        rdy_mode = 0;
        chk("bp_n_words", 32'(out_q.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("bp_word%0d", i), out_q[i], 32'h100 + 32'(i));
        chk("bp_last7", 32'(out_last[7]), 32'd1);
        chk("bp_last6", 32'(out_last[6]), 32'd0);
        chk("bp_stable", 32'(stall_bad), 32'd0);
        chk("bp_no_bus_in_hold", 32'(hold_bus_bad), 32'd0);

        // len = 0
        do_start(1'b0, 32'h3800_0000, 16'd0);
        k = 0; seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk); k++;
            if (done) seen = 1;
        end
        chk("len0_done_ok", 32'(seen && k >= 1 && k <= 2), 32'd1);
        repeat (3) @(negedge clk);
        chk("len0_no_cyc", 32'(cyc_cnt), 32'd0);
        chk("len0_done_cnt", 32'(done_cnt), 32'd1);

        // Start while busy is ignored
        mem[0] = 32'h7; mem[1] = 32'h8;
        do_start(1'b0, 32'h3800_0000, 16'd2);
        @(posedge clk); #1;
        start = 1'b1; dir = 1'b1; base = 32'h3800_0100; len = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(40, "busy_ign");
        repeat (6) @(negedge clk);
        chk("busy_ign_n_words", 32'(out_q.size()), 32'd2);
        chk("busy_ign_w0", out_q[0], 32'h7);
        chk("busy_ign_w1", out_q[1], 32'h8);
        chk("busy_ign_done_cnt", 32'(done_cnt), 32'd1);
        chk("busy_ign_n_acc", 32'(acc_adr.size()), 32'd2);
        chk("busy_ign_idle", 32'(busy), 32'd0);

        // Timeout: RAM never acks
        noack = 1'b1;
        do_start(1'b0, 32'h3800_0000, 16'd2);
        wait_done(60, "to");
        repeat (3) @(negedge clk);
        chk("to_cyc_cycles", 32'(cyc_cnt), 32'd16);
        chk("to_err", 32'(err), 32'd1);
        chk("to_no_out", 32'(out_q.size()), 32'd0);
        chk("to_done_cnt", 32'(done_cnt), 32'd1);
        noack = 1'b0;
        src_data[0] = 32'h77;
        set_src(1);
        do_start(1'b1, 32'h3800_00C0, 16'd1);
        @(negedge clk);
        chk("to_err_cleared", 32'(err), 32'd0);
        wait_done(40, "to_next");
        repeat (2) @(negedge clk);
        chk("to_next_mem", mem[48], 32'h77);
        chk("to_next_err", 32'(err), 32'd0);

        // Reset mid-write
        src_data[0] = 32'h11; src_data[1] = 32'h22; src_data[2] = 32'h33;
        set_src(3);
        do_start(1'b1, 32'h3800_00A0, 16'd3);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (cyc) seen = 1;
        end
        chk("rstm_cyc_seen", 32'(seen), 32'd1);
        #1 rst_n = 1'b0;
        src_len = 0;
        #1;
        chk("rstm_bus", {29'd0, cyc, stb, we}, 32'd0);
        chk("rstm_sel", {28'd0, sel}, 32'd0);
        chk("rstm_adr", adr, 32'd0);
        chk("rstm_dat", dat_o, 32'd0);
        chk("rstm_ctrl", {26'd0, busy, done, err, m_tvalid, m_tlast, s_tready}, 32'd0);
        chk("rstm_tdata", m_tdata, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        src_data[0] = 32'h5A;
        set_src(1);
        do_start(1'b1, 32'h3800_00B0, 16'd1);
        wait_done(40, "rstm_next");
        repeat (2) @(negedge clk);
        chk("rstm_next_mem", mem[44], 32'h5A);
        chk("rstm_next_n_acc", 32'(acc_adr.size()), 32'd1);
        chk("rstm_next_err", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
